// File: rtl/sw_handshake_ctrl_if.sv
// ---------------------------------------------------------------------------
// sw_handshake_ctrl_if
// Bundle of the signals between the operator switches, the decoder, the PC
// block and the handshake controller.
//   btn_raw      raw SW8 handshake button (asynchronous to clk)
//   sw_raw       raw SW[n-1:0] data switches
//   wait_press   decoder: instruction waits for the button to be pressed
//   wait_release decoder: instruction waits for the button to be released
//   pc_hold      freeze the program counter (1 = hold)
//   sw_data      switch word latched at the last accepted press
//   data_valid   one-cycle pulse when sw_data is updated
//   btn_level    debounced button level
//   press_count  accepted presses, wraps 255 -> 0
// The slave modport is the controller's view; master is the surrounding
// system (switch pins, decoder and pc block).
// ---------------------------------------------------------------------------
interface sw_handshake_ctrl_if #(
  parameter int n = 8
);
  logic         btn_raw;
  logic [n-1:0] sw_raw;
  logic         wait_press;
  logic         wait_release;
  logic         pc_hold;
  logic [n-1:0] sw_data;
  logic         data_valid;
  logic         btn_level;
  logic [7:0]   press_count;

  modport slave (
    input  btn_raw, sw_raw, wait_press, wait_release,
    output pc_hold, sw_data, data_valid, btn_level, press_count
  );

  modport master (
    output btn_raw, sw_raw, wait_press, wait_release,
    input  pc_hold, sw_data, data_valid, btn_level, press_count
  );
endinterface

// File: rtl/sw_handshake_ctrl.sv
// ---------------------------------------------------------------------------
// sw_handshake_ctrl
// Sequencing controller between the operator switches and the picoMIPS
// program counter. Synchronises and debounces the SW8 handshake button,
// latches the switch word on each qualified press and holds the PC while the
// decoder waits for a press or a release.
// Ports:
//   clk     system clock
//   nReset  asynchronous active-low reset
//   hs      handshake bundle (slave view), see sw_handshake_ctrl_if
// Parameters:
//   n           width of the captured switch word
//   DEB_CYCLES  consecutive stable cycles needed to accept a level change
//   CW          debounce counter width, 2**CW > DEB_CYCLES
// ---------------------------------------------------------------------------
module sw_handshake_ctrl #(
  parameter int n          = 8,
  parameter int DEB_CYCLES = 16,
  parameter int CW         = 5
) (
  input logic                 clk,
  input logic                 nReset,
  sw_handshake_ctrl_if.slave  hs
);

  localparam logic [1:0] LO     = 2'd0;
  localparam logic [1:0] CHK_HI = 2'd1;
  localparam logic [1:0] HI     = 2'd2;
  localparam logic [1:0] CHK_LO = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic         btn_meta;
  logic         btn_s;
  logic [n-1:0] sw_meta;
  logic [n-1:0] sw_s;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;

  logic [n-1:0] sw_data_r;
  logic         data_valid_r;
  logic [7:0]   press_count_r;
  logic         level;

  // Two-flop synchronisers; the switch word is only sampled on an accepted
  // press, long after it has settled, so it is not debounced.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_meta <= hs.btn_raw;
      btn_s    <= btn_meta;
      sw_meta  <= hs.sw_raw;
      sw_s     <= sw_meta;
    end
  end

  // Debounce FSM. The counter is cleared on every state change, so a bounce
  // back to the stable state always restarts the qualification from zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      LO: begin
        if (btn_s) begin
          state_next = CHK_HI;
          cnt_next   = '0;
        end
      end
      CHK_HI: begin
        if (!btn_s) begin
          state_next = LO;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HI;
          cnt_next   = '0;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HI: begin
        if (!btn_s) begin
          state_next = CHK_LO;
          cnt_next   = '0;
        end
      end
      CHK_LO: begin
        if (btn_s) begin
          state_next = HI;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = LO;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= LO;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Press side effects share the CHK_HI -> HI edge, so data_valid and
  // btn_level rise together; releases have no data side effects.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sw_data_r     <= '0;
      data_valid_r  <= 1'b0;
      press_count_r <= '0;
    end else begin
      data_valid_r <= accept;
      if (accept) begin
        sw_data_r     <= sw_s;
        press_count_r <= press_count_r + 8'd1;
      end
    end
  end

  // The level is still high while a release is being qualified.
  assign level = (state == HI) || (state == CHK_LO);

  // Combinational so the stall starts in the cycle the decoder asks for it.
  // With both waits asserted one term is always true, so an illegal decode
  // never lets the PC run.
  assign hs.pc_hold     = (hs.wait_press & ~level) | (hs.wait_release & level);
  assign hs.btn_level   = level;
  assign hs.sw_data     = sw_data_r;
  assign hs.data_valid  = data_valid_r;
  assign hs.press_count = press_count_r;

endmodule
